// File: rtl/mips_irq_pkg.sv
// Shared constants for the MIPS interrupt controller:
// register offsets, DROP width and the reset routing helper.
package mips_irq_pkg;

  localparam logic [2:0] IRQ_PEND   = 3'd0;
  localparam logic [2:0] IRQ_MASK   = 3'd1;
  localparam logic [2:0] IRQ_MODE   = 3'd2;
  localparam logic [2:0] IRQ_ROUTE  = 3'd3;
  localparam logic [2:0] IRQ_ACTIVE = 3'd4;
  localparam logic [2:0] IRQ_DROP   = 3'd5;

  localparam int DROP_W  = 16;
  localparam int ACT_VLD = 31;

  // Source i routed to INT line i%4.
  function automatic logic [31:0] route_rst(int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[2*i +: 2] = 2'(i % 4);
    return r;
  endfunction

endpackage

// File: rtl/mips_irq_ctrl_if.sv
// Data-memory bus slice seen by the interrupt controller.
// Single-cycle access: no stalls, read data is combinational.
interface mips_irq_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;

  modport master (
    output we, addr, wd,
    input  rd, hit
  );

  modport slave (
    input  we, addr, wd,
    output rd, hit
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Three-flop synchroniser with rising-edge detect for
// one asynchronous request line.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic lvl_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/mips_irq_ctrl.sv
// Memory-mapped interrupt controller driving the core's
// INT[3:0]: sync, edge latch, mask, route, priority.
module mips_irq_ctrl
  import mips_irq_pkg::*;
#(
  parameter int          NSRC     = 8,
  parameter logic [31:0] BASE     = 32'h0000_7F00,
  parameter logic [15:0] MODE_RST = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  irq_src,
  mips_irq_ctrl_if.slave   bus,
  output logic [3:0]       INT
);

  localparam logic [31:0] ROUTE_RST = route_rst(NSRC);

  logic [NSRC-1:0]   lvl, rise;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [NSRC-1:0]   mode_q, mode_d;
  logic [2*NSRC-1:0] route_q, route_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [3:0]        int_q, int_d;

  logic [NSRC-1:0] clr, pm;
  logic [2:0]      idx;
  logic            wr, drop_ev;
  logic            act_vld;
  logic [3:0]      act_idx;
  logic [31:0]     rdata;
  logic            unused_ok;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge u_se (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (irq_src[g]),
      .lvl_o  (lvl[g]),
      .rise_o (rise[g])
    );
  end

  assign unused_ok = ^{bus.addr[1:0], bus.wd};

  assign bus.hit = bus.addr[31:5] == BASE[31:5];
  assign idx     = bus.addr[4:2];
  assign wr      = bus.we & bus.hit;
  assign clr     = (wr && idx == IRQ_PEND) ? bus.wd[NSRC-1:0] : '0;
  assign pm      = pend_q & mask_q;

  // A drop is a new edge landing on a bit that stays set.
  assign drop_ev = |(mode_q & rise & pend_q & ~clr);

  always_comb begin
    act_vld = 1'b0;
    act_idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pm[i]) begin
        act_vld = 1'b1;
        act_idx = 4'(i);
      end
    end
  end

  always_comb begin
    int_d = 4'd0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NSRC; i++)
        if (pm[i] && route_q[2*i +: 2] == 2'(k))
          int_d[k] = 1'b1;
  end

  always_comb begin
    pend_d  = pend_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    route_d = route_q;
    drop_d  = drop_q;
    for (int i = 0; i < NSRC; i++)
      pend_d[i] = mode_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i])
                            : lvl[i];
    if (wr && idx == IRQ_MASK)  mask_d  = bus.wd[NSRC-1:0];
    if (wr && idx == IRQ_MODE)  mode_d  = bus.wd[NSRC-1:0];
    if (wr && idx == IRQ_ROUTE) route_d = bus.wd[2*NSRC-1:0];
    if (wr && idx == IRQ_DROP)
      drop_d = '0;
    else if (drop_ev && drop_q != '1)
      drop_d = drop_q + 1'b1;
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      IRQ_PEND:   rdata = 32'(pend_q);
      IRQ_MASK:   rdata = 32'(mask_q);
      IRQ_MODE:   rdata = 32'(mode_q);
      IRQ_ROUTE:  rdata = 32'(route_q);
      IRQ_ACTIVE: begin
        rdata[ACT_VLD] = act_vld;
        rdata[3:0]     = act_idx;
      end
      IRQ_DROP:   rdata = 32'(drop_q);
      default:    rdata = 32'd0;
    endcase
  end

  assign bus.rd = bus.hit ? rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= MODE_RST[NSRC-1:0];
      route_q <= ROUTE_RST[2*NSRC-1:0];
      drop_q  <= '0;
      int_q   <= 4'd0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      route_q <= route_d;
      drop_q  <= drop_d;
      int_q   <= int_d;
    end
  end

  assign INT = int_q;

endmodule
